// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: sizes, the reserved no-tag value and the ROB entry
// layout shared by the reorder buffer and anything that talks ROB tags.
package reorder_buffer_pkg;

    localparam int ROB_TAG_LEN  = 3;
    // One tag value is reserved as "no tag", so the ROB holds one entry
    // fewer than the tag space and is deliberately not a power of two.
    localparam int ROB_SIZE     = (1 << ROB_TAG_LEN) - 1;
    localparam int REG_ADDR_LEN = 5;
    localparam int XLEN         = 32;

    // All-ones tag marks "no producer"; it is never allocated.
    localparam logic [ROB_TAG_LEN-1:0] NO_TAG = '1;

    typedef struct packed {
        logic                    busy;
        logic                    ready;
        logic [REG_ADDR_LEN-1:0] dest;
        logic [XLEN-1:0]         value;
    } ROB_ENTRY;

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer for the Tomasulo core. Hands out
// ROB tags at dispatch, captures CDB results, and retires entries in program
// order through the commit/return handshake.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    dispatch_valid,
    input  logic [REG_ADDR_LEN-1:0] dispatch_dest,
    output logic                    dispatch_ready,
    output logic                    assign_flag,
    output logic [ROB_TAG_LEN-1:0]  assign_rob_tag,
    input  logic                    cdb_valid,
    input  logic [ROB_TAG_LEN-1:0]  cdb_rob_tag,
    input  logic [XLEN-1:0]         cdb_value,
    input  logic [ROB_TAG_LEN-1:0]  read_tag1,
    input  logic [ROB_TAG_LEN-1:0]  read_tag2,
    output logic [XLEN-1:0]         read_value1,
    output logic [XLEN-1:0]         read_value2,
    output logic                    return_flag,
    output logic [REG_ADDR_LEN-1:0] reg_addr_from_rob,
    output logic [ROB_TAG_LEN-1:0]  rob_tag_from_rob,
    output logic [XLEN-1:0]         commit_value,
    output logic [ROB_TAG_LEN-1:0]  count
);

    localparam logic [ROB_TAG_LEN-1:0] LAST_IDX  = ROB_TAG_LEN'(ROB_SIZE - 1);
    localparam logic [ROB_TAG_LEN-1:0] FULL_CNT  = ROB_TAG_LEN'(ROB_SIZE);

    ROB_ENTRY                entries_q [ROB_SIZE];
    ROB_ENTRY                entries_d [ROB_SIZE];
    logic [ROB_TAG_LEN-1:0]  head_q, head_d;
    logic [ROB_TAG_LEN-1:0]  tail_q, tail_d;
    logic [ROB_TAG_LEN-1:0]  count_q, count_d;

    // The size is not a power of two, so wrapping needs an explicit compare
    // against the last index rather than letting the pointer overflow.
    function automatic logic [ROB_TAG_LEN-1:0] nextPtr(input logic [ROB_TAG_LEN-1:0] ptr);
        return (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
    endfunction

    // A tag names a real entry only if it is not the reserved value and
    // lies inside the buffer.
    function automatic logic tagValid(input logic [ROB_TAG_LEN-1:0] tag);
        return (tag != NO_TAG) && (tag < FULL_CNT);
    endfunction

    // Handshake flags: no same-cycle bypass, so a full ROB refuses dispatch
    // even when the head is retiring this cycle.
    always_comb begin
        dispatch_ready = (count_q < FULL_CNT);
        assign_flag    = dispatch_valid & dispatch_ready;
        assign_rob_tag = tail_q;
        return_flag    = entries_q[head_q].busy & entries_q[head_q].ready;
        count          = count_q;
    end

    // Commit outputs show the head entry only while it is retiring.
    always_comb begin
        reg_addr_from_rob = '0;
        rob_tag_from_rob  = '0;
        commit_value      = '0;
        if (return_flag) begin
            reg_addr_from_rob = entries_q[head_q].dest;
            rob_tag_from_rob  = head_q;
            commit_value      = entries_q[head_q].value;
        end
    end

    // Operand lookups for the rename stage; invalid tags read as zero.
    always_comb begin
        read_value1 = '0;
        read_value2 = '0;
        if (tagValid(read_tag1)) begin
            read_value1 = entries_q[read_tag1].value;
        end
        if (tagValid(read_tag2)) begin
            read_value2 = entries_q[read_tag2].value;
        end
    end

    // Next-state: flush squashes everything; otherwise CDB capture, head
    // retirement and tail allocation can all happen in the same cycle.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_d[i].busy  = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_valid && tagValid(cdb_rob_tag) && entries_q[cdb_rob_tag].busy) begin
                entries_d[cdb_rob_tag].ready = 1'b1;
                entries_d[cdb_rob_tag].value = cdb_value;
            end
            if (return_flag) begin
                entries_d[head_q].busy = 1'b0;
                head_d                 = nextPtr(head_q);
            end
            if (assign_flag) begin
                entries_d[tail_q].busy  = 1'b1;
                entries_d[tail_q].ready = 1'b0;
                entries_d[tail_q].dest  = dispatch_dest;
                entries_d[tail_q].value = '0;
                tail_d                  = nextPtr(tail_q);
            end
            count_d = count_q + ROB_TAG_LEN'(assign_flag) - ROB_TAG_LEN'(return_flag);
        end
    end

    // State register; reset discards every entry immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic, checked
// against a program-order queue model of the reorder buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    flush = 1'b0;
    logic                    dispatch_valid = 1'b0;
    logic [REG_ADDR_LEN-1:0] dispatch_dest = '0;
    logic                    dispatch_ready;
    logic                    assign_flag;
    logic [ROB_TAG_LEN-1:0]  assign_rob_tag;
    logic                    cdb_valid = 1'b0;
    logic [ROB_TAG_LEN-1:0]  cdb_rob_tag = '0;
    logic [XLEN-1:0]         cdb_value = '0;
    logic [ROB_TAG_LEN-1:0]  read_tag1 = '0;
    logic [ROB_TAG_LEN-1:0]  read_tag2 = '0;
    logic [XLEN-1:0]         read_value1;
    logic [XLEN-1:0]         read_value2;
    logic                    return_flag;
    logic [REG_ADDR_LEN-1:0] reg_addr_from_rob;
    logic [ROB_TAG_LEN-1:0]  rob_tag_from_rob;
    logic [XLEN-1:0]         commit_value;
    logic [ROB_TAG_LEN-1:0]  count;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_dest(dispatch_dest),
        .dispatch_ready(dispatch_ready), .assign_flag(assign_flag),
        .assign_rob_tag(assign_rob_tag),
        .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_value(cdb_value),
        .read_tag1(read_tag1), .read_tag2(read_tag2),
        .read_value1(read_value1), .read_value2(read_value2),
        .return_flag(return_flag), .reg_addr_from_rob(reg_addr_from_rob),
        .rob_tag_from_rob(rob_tag_from_rob), .commit_value(commit_value),
        .count(count)
    );

    // Model: in-flight tags in program order, plus per-tag result state.
    int              mQ[$];
    bit              mReady [ROB_SIZE];
    logic [XLEN-1:0] mValue [ROB_SIZE];
    logic [4:0]      mDest  [ROB_SIZE];
    int              mTail = 0;

    function automatic bit inFlight(int t);
        foreach (mQ[i]) if (mQ[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit expRet();
        return (mQ.size() > 0) && mReady[mQ[0]];
    endfunction

    function automatic bit expReady();
        return mQ.size() < ROB_SIZE;
    endfunction

    function automatic logic [XLEN-1:0] expRead(logic [ROB_TAG_LEN-1:0] t);
        int idx;
        idx = int'(t);
        if (idx < ROB_SIZE) return mValue[idx];
        return '0;
    endfunction

    task automatic expectValue(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance on each edge, or immediate clear on reset.
    always @(posedge clk or posedge reset) begin
        bit ret;
        bit asg;
        if (reset) begin
            mQ.delete();
            mTail = 0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                mReady[i] = 1'b0;
                mValue[i] = '0;
                mDest[i]  = '0;
            end
        end else begin
            ret = expRet();
            asg = dispatch_valid && expReady();
            if (flush) begin
                mQ.delete();
                mTail = 0;
                for (int i = 0; i < ROB_SIZE; i++) mReady[i] = 1'b0;
            end else begin
                if (cdb_valid && int'(cdb_rob_tag) < ROB_SIZE && inFlight(int'(cdb_rob_tag))) begin
                    mReady[cdb_rob_tag] = 1'b1;
                    mValue[cdb_rob_tag] = cdb_value;
                end
                if (ret) void'(mQ.pop_front());
                if (asg) begin
                    mQ.push_back(mTail);
                    mReady[mTail] = 1'b0;
                    mValue[mTail] = '0;
                    mDest[mTail]  = dispatch_dest;
                    mTail = (mTail + 1) % ROB_SIZE;
                end
            end
        end
    end

    task automatic checkOutput();
        bit ret;
        ret = expRet();
        expectValue("count", XLEN'(count), XLEN'(mQ.size()));
        expectValue("dispatch_ready", XLEN'(dispatch_ready), XLEN'(expReady()));
        expectValue("assign_flag", XLEN'(assign_flag), XLEN'(dispatch_valid && expReady()));
        expectValue("assign_rob_tag", XLEN'(assign_rob_tag), XLEN'(mTail));
        expectValue("return_flag", XLEN'(return_flag), XLEN'(ret));
        expectValue("reg_addr_from_rob", XLEN'(reg_addr_from_rob), ret ? XLEN'(mDest[mQ[0]]) : '0);
        expectValue("rob_tag_from_rob", XLEN'(rob_tag_from_rob), ret ? XLEN'(mQ[0]) : '0);
        expectValue("commit_value", commit_value, ret ? mValue[mQ[0]] : '0);
        expectValue("read_value1", read_value1, expRead(read_tag1));
        expectValue("read_value2", read_value2, expRead(read_tag2));
    endtask

    // Compare process: outputs are checked mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(int flushOdds);
        dispatch_valid = ($urandom_range(0, 2) != 0);
        dispatch_dest  = REG_ADDR_LEN'($urandom);
        cdb_valid      = ($urandom_range(0, 3) != 0);
        if (mQ.size() > 0 && $urandom_range(0, 3) != 0)
            cdb_rob_tag = ROB_TAG_LEN'(mQ[$urandom_range(0, mQ.size() - 1)]);
        else
            cdb_rob_tag = ROB_TAG_LEN'($urandom_range(0, 7));
        cdb_value = $urandom;
        read_tag1 = ROB_TAG_LEN'($urandom_range(0, 7));
        read_tag2 = ROB_TAG_LEN'($urandom_range(0, 7));
        flush     = (flushOdds > 0) && ($urandom_range(1, flushOdds) == 1);
    endtask

    initial begin
        #1 reset = 1'b1;
        #12 reset = 1'b0;
        checkEn = 1'b1;
        #1;
        expectValue("reset_count", XLEN'(count), 0);
        expectValue("reset_dispatch_ready", XLEN'(dispatch_ready), 1);
        expectValue("reset_assign_tag", XLEN'(assign_rob_tag), 0);
        expectValue("reset_return_flag", XLEN'(return_flag), 0);
        expectValue("reset_commit_value", commit_value, 0);
        tick();

        // Fill with dests 1..7; the eighth request is refused.
        for (int i = 1; i <= 7; i++) begin
            dispatch_valid = 1'b1;
            dispatch_dest  = REG_ADDR_LEN'(i);
            #1;
            expectValue("fill_assign_tag", XLEN'(assign_rob_tag), XLEN'(i - 1));
            expectValue("fill_assign_flag", XLEN'(assign_flag), 1);
            tick();
        end
        dispatch_dest = 5'd8;
        #1;
        expectValue("full_assign_flag", XLEN'(assign_flag), 0);
        expectValue("full_dispatch_ready", XLEN'(dispatch_ready), 0);
        expectValue("full_count", XLEN'(count), 7);
        tick();

        // Out-of-order completion, in-order retirement.
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_rob_tag = 3'd2; cdb_value = 32'h22;
        #1 expectValue("ooo_no_commit_t2", XLEN'(return_flag), 0);
        tick();
        cdb_rob_tag = 3'd0; cdb_value = 32'h00;
        #1 expectValue("ooo_no_commit_t0", XLEN'(return_flag), 0);
        tick();
        cdb_rob_tag = 3'd1; cdb_value = 32'h11;
        dispatch_valid = 1'b1; dispatch_dest = 5'd9;
        #1;
        expectValue("commit0_flag", XLEN'(return_flag), 1);
        expectValue("commit0_tag", XLEN'(rob_tag_from_rob), 0);
        expectValue("commit0_value", commit_value, 32'h00);
        expectValue("commit0_dest", XLEN'(reg_addr_from_rob), 1);
        expectValue("full_no_bypass", XLEN'(assign_flag), 0);
        tick();
        cdb_valid = 1'b0;
        #1;
        expectValue("commit1_tag", XLEN'(rob_tag_from_rob), 1);
        expectValue("commit1_value", commit_value, 32'h11);
        expectValue("alloc_during_commit", XLEN'(assign_flag), 1);
        expectValue("alloc_wrapped_tag", XLEN'(assign_rob_tag), 0);
        expectValue("count_during_swap", XLEN'(count), 6);
        tick();
        #1;
        expectValue("commit2_tag", XLEN'(rob_tag_from_rob), 2);
        expectValue("commit2_value", commit_value, 32'h22);
        expectValue("alloc_tag_1", XLEN'(assign_rob_tag), 1);
        expectValue("count_unchanged", XLEN'(count), 6);
        tick();

        // CDB on the head: commit appears one cycle later.
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_rob_tag = 3'd3; cdb_value = 32'h5;
        #1 expectValue("head_cdb_same_cycle", XLEN'(return_flag), 0);
        tick();
        cdb_valid = 1'b0;
        #1;
        expectValue("head_cdb_next_flag", XLEN'(return_flag), 1);
        expectValue("head_cdb_next_value", commit_value, 32'h5);
        expectValue("head_cdb_next_tag", XLEN'(rob_tag_from_rob), 3);
        tick();

        // Broadcasts on an idle tag and on the reserved tag change nothing.
        cdb_valid = 1'b1; cdb_rob_tag = 3'd2; cdb_value = 32'hDEAD;
        read_tag1 = 3'd2; read_tag2 = 3'd7;
        tick();
        cdb_rob_tag = 3'd7; cdb_value = 32'hBEEF;
        tick();
        cdb_valid = 1'b0;
        #1;
        expectValue("idle_cdb_value", read_value1, 32'h22);
        expectValue("no_tag_read", read_value2, 0);
        expectValue("idle_cdb_count", XLEN'(count), 5);

        // Sustained dispatch with head completions to wrap the tail.
        for (int i = 0; i < 14; i++) begin
            dispatch_valid = 1'b1;
            dispatch_dest  = REG_ADDR_LEN'($urandom);
            cdb_valid      = (mQ.size() > 0);
            cdb_rob_tag    = (mQ.size() > 0) ? ROB_TAG_LEN'(mQ[0]) : 3'd0;
            cdb_value      = $urandom;
            tick();
        end

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(40);
            tick();
        end
        flush = 1'b0; cdb_valid = 1'b0; dispatch_valid = 1'b0;

        // Flush with four busy entries while the head is committing.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dispatch_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dispatch_dest = REG_ADDR_LEN'(i + 10);
            tick();
        end
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_rob_tag = 3'd0; cdb_value = 32'h77;
        tick();
        cdb_valid = 1'b0; flush = 1'b1;
        #1;
        expectValue("flush_cycle_commit", XLEN'(return_flag), 1);
        expectValue("flush_cycle_value", commit_value, 32'h77);
        expectValue("flush_cycle_count", XLEN'(count), 4);
        tick();
        flush = 1'b0;
        #1;
        expectValue("post_flush_count", XLEN'(count), 0);
        expectValue("post_flush_tag", XLEN'(assign_rob_tag), 0);
        expectValue("post_flush_return", XLEN'(return_flag), 0);
        tick();

        // Asynchronous reset between edges with a commit pending.
        dispatch_valid = 1'b1; dispatch_dest = 5'd3;
        tick();
        cdb_valid = 1'b1; cdb_rob_tag = 3'd0; cdb_value = 32'h99;
        tick();
        dispatch_valid = 1'b0; cdb_valid = 1'b0;
        #1 expectValue("pre_reset_return", XLEN'(return_flag), 1);
        #1 reset = 1'b1;
        #1;
        expectValue("async_reset_count", XLEN'(count), 0);
        expectValue("async_reset_return", XLEN'(return_flag), 0);
        expectValue("async_reset_value", commit_value, 0);
        expectValue("async_reset_ready", XLEN'(dispatch_ready), 1);
        #3 reset = 1'b0;
        tick();
        for (int i = 0; i < 50; i++) begin
            applyStimulus(0);
            tick();
        end
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
